// File: rtl/adc_arbiter_pkg.sv
// Shared types and round-robin search helper for the ADC stream arbiter.
package adc_arbiter_pkg;

    localparam int MAX_CH = 16;
    localparam int IDX_W  = 4;
    localparam int STAT_W = 16;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask strictly after pointer, wrapping within n entries.
    function automatic rr_pick_t rr_next(
        input logic [MAX_CH-1:0] mask,
        input logic [IDX_W-1:0]  pointer,
        input int                n
    );
        rr_pick_t r;
        int       j;
        r = '0;
        j = 0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= n) begin
                j = (int'(pointer) + k) % n;
                if (!r.hit && mask[j]) begin
                    r.hit = 1'b1;
                    r.idx = IDX_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin search over the eligible channels.
module rr_priority_picker
    import adc_arbiter_pkg::*;
#(
    parameter int N_CHANNELS = 4
) (
    input  logic [N_CHANNELS-1:0]         request,
    input  logic [$clog2(N_CHANNELS)-1:0] pointer,
    output logic                          grant_valid,
    output logic [$clog2(N_CHANNELS)-1:0] grant_idx
);

    localparam int W = $clog2(N_CHANNELS);

    logic [MAX_CH-1:0] mask_ext;
    rr_pick_t          pick;

    always_comb begin
        mask_ext = '0;
        mask_ext[N_CHANNELS-1:0] = request;
        pick = rr_next(mask_ext, IDX_W'(pointer), N_CHANNELS);
        grant_valid = pick.hit;
        grant_idx = W'(pick.idx);
    end

endmodule

// File: rtl/adc_stream_arbiter.sv
// Round-robin burst arbiter feeding one shared AdcProcessing datapath.
// Optional per-channel grant counters under ADC_ARB_STATS_EN.
module adc_stream_arbiter
    import adc_arbiter_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [N_CHANNELS-1:0]            in_valid,
    output logic [N_CHANNELS-1:0]            in_ready,
    input  logic [N_CHANNELS-1:0]            channel_enable,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(N_CHANNELS)-1:0]    out_dest,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             burst_abort,
    output logic [$clog2(N_CHANNELS)-1:0]    active_channel
`ifdef ADC_ARB_STATS_EN
    ,
    output logic [N_CHANNELS*STAT_W-1:0]     grant_count
`endif
);

    localparam int W  = $clog2(N_CHANNELS);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t            state;
    logic [W-1:0]          rr_ptr;
    logic [7:0]            beat_cnt;
    logic [TW-1:0]         idle_cnt;
    logic                  grant_valid;
    logic [W-1:0]          grant_idx;
    logic                  can_issue;
    logic                  act_valid;
    logic                  act_enable;
    logic                  accept;
    logic                  last_beat;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] act_data;

    rr_priority_picker #(
        .N_CHANNELS(N_CHANNELS)
    ) u_picker (
        .request    (in_valid & channel_enable),
        .pointer    (rr_ptr),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    // A disabled active channel is never handshaken, so nothing is lost on abort.
    always_comb begin
        can_issue  = !out_valid || out_ready;
        act_valid  = in_valid[active_channel];
        act_enable = channel_enable[active_channel];
        act_data   = in_data[int'(active_channel)*DATA_WIDTH +: DATA_WIDTH];
        in_ready   = '0;
        if (state == BURST && act_enable)
            in_ready[active_channel] = can_issue;
        accept    = (state == BURST) && act_enable && act_valid && can_issue;
        last_beat = beat_cnt == 8'(BURST_LEN - 1);
        timed_out = idle_cnt == TW'(TIMEOUT - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= W'(N_CHANNELS - 1);
            active_channel <= '0;
            beat_cnt       <= '0;
            idle_cnt       <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_dest       <= '0;
            burst_abort    <= 1'b0;
        end else begin
            burst_abort <= 1'b0;
            if (accept) begin
                out_data  <= act_data;
                out_dest  <= active_channel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        active_channel <= grant_idx;
                        beat_cnt       <= '0;
                        idle_cnt       <= '0;
                        state          <= BURST;
                    end
                end
                BURST: begin
                    if (!act_enable) begin
                        burst_abort <= 1'b1;
                        rr_ptr      <= active_channel;
                        state       <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        idle_cnt <= '0;
                        if (last_beat) begin
                            rr_ptr <= active_channel;
                            state  <= IDLE;
                        end
                    end else if (!act_valid && can_issue) begin
                        // Starved, not stalled by the sink: count toward timeout.
                        if (timed_out) begin
                            burst_abort <= 1'b1;
                            rr_ptr      <= active_channel;
                            state       <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef ADC_ARB_STATS_EN
    logic [STAT_W-1:0] grants [N_CHANNELS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++)
                grants[i] <= '0;
        end else if (accept && last_beat) begin
            grants[active_channel] <= grants[active_channel] + STAT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++)
            grant_count[i*STAT_W +: STAT_W] = grants[i];
    end
`endif

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// Self-checking bench for adc_stream_arbiter with a transaction-level model.
module tb_adc_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int TO = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    channel_enable = '0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_dest;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            burst_abort;
    logic [1:0]      active_channel;
`ifdef ADC_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    logic [15:0] sample_mem [N][256];
    logic [7:0]  src_cnt [N];
    bit          const_mode = 1'b0;

    typedef struct {
        int          dest;
        logic [15:0] data;
        int          cyc;
    } beat_t;

    beat_t obs[$];

    adc_stream_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .channel_enable(channel_enable),
        .out_data      (out_data),
        .out_dest      (out_dest),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .burst_abort   (burst_abort),
        .active_channel(active_channel)
`ifdef ADC_ARB_STATS_EN
        ,
        .grant_count   (grant_count)
`endif
    );

    always #5 clock = ~clock;

    // Each source presents its next sample; counter advances on handshake.
    always_comb begin
        for (int i = 0; i < N; i++)
            in_data[i*DW +: DW] = const_mode ? 16'h1000 + 16'(i)
                                             : sample_mem[i][src_cnt[i]];
    end

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (reset)
                src_cnt[i] <= 8'd0;
            else if (in_valid[i] && in_ready[i])
                src_cnt[i] <= src_cnt[i] + 8'd1;
        end
    end

    // Record output beats that will complete at the next rising edge.
    always @(negedge clock) begin
        #1;
        cyc++;
        if (!reset && out_valid && out_ready)
            obs.push_back('{int'(out_dest), out_data, cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        obs.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = '0;
        channel_enable = '1;
        out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        in_valid = '1;
        @(negedge clock);
        #2;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (out_data !== 16'h0) $display("FAIL rst_out_data: got %0h want 0", out_data);
        else pass_cnt++;
        check_cnt++;
        if (out_dest !== 2'd0) $display("FAIL rst_out_dest: got %0d want 0", out_dest);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 4'b0) $display("FAIL rst_in_ready: got %b want 0000", in_ready);
        else pass_cnt++;
        check_cnt++;
        if (burst_abort !== 1'b0) $display("FAIL rst_abort: got %0b want 0", burst_abort);
        else pass_cnt++;
        check_cnt++;
        if (active_channel !== 2'd0) $display("FAIL rst_active: got %0d want 0", active_channel);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #2;
        check_cnt++;
        if (in_ready !== 4'b0001) $display("FAIL first_grant: in_ready %b want 0001", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        const_mode = 1'b1;
        in_valid = '1;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 200 && obs.size() < 20; k++) @(negedge clock);
        #2;
        check_cnt++;
        if (obs.size() < 20) begin
            $display("FAIL rr_count: got %0d beats want 20", obs.size());
            const_mode = 1'b0;
            return;
        end
        pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            int ed = (n / BL) % N;
            check_cnt++;
            if (obs[n].dest != ed || obs[n].data !== 16'h1000 + 16'(ed))
                $display("FAIL rr_beat%0d: dest %0d data %0h want dest %0d data %0h",
                         n, obs[n].dest, obs[n].data, ed, 16'h1000 + 16'(ed));
            else pass_cnt++;
            if (n > 0) begin
                int eg = (n % BL == 0) ? 2 : 1;
                check_cnt++;
                if (obs[n].cyc - obs[n-1].cyc != eg)
                    $display("FAIL rr_gap%0d: got %0d want %0d",
                             n, obs[n].cyc - obs[n-1].cyc, eg);
                else pass_cnt++;
            end
        end
        const_mode = 1'b0;
    endtask

    task automatic test_single_channel();
        in_valid = 4'b0100;
        channel_enable = 4'b0100;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 100 && obs.size() < 12; k++) @(negedge clock);
        #2;
        check_cnt++;
        if (obs.size() < 12) begin
            $display("FAIL single_count: got %0d want 12", obs.size());
            return;
        end
        pass_cnt++;
        for (int n = 0; n < 12; n++) begin
            check_cnt++;
            if (obs[n].dest != 2 || obs[n].data !== sample_mem[2][n])
                $display("FAIL single_beat%0d: dest %0d data %0h want dest 2 data %0h",
                         n, obs[n].dest, obs[n].data, sample_mem[2][n]);
            else pass_cnt++;
        end
        for (int b = 0; b < 3; b++) begin
            int so = 0;
            int se = 0;
            for (int i = 0; i < BL; i++) begin
                so += int'(obs[b*BL+i].data);
                se += int'(sample_mem[2][b*BL+i]);
            end
            check_cnt++;
            if (so / BL != se / BL)
                $display("FAIL single_avg%0d: got %0d want %0d", b, so / BL, se / BL);
            else pass_cnt++;
            if (b > 0) begin
                check_cnt++;
                if (obs[b*BL].cyc - obs[b*BL-1].cyc != 2)
                    $display("FAIL single_gap%0d: got %0d want 2",
                             b, obs[b*BL].cyc - obs[b*BL-1].cyc);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_timeout_abort();
        int wait_k = -1;
        int extra = 0;
        in_valid = 4'b0010;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 50 && src_cnt[1] != 8'd2; k++) @(negedge clock);
        check_cnt++;
        if (src_cnt[1] != 8'd2) begin
            $display("FAIL to_start: ch1 accepted %0d want 2", src_cnt[1]);
            return;
        end
        pass_cnt++;
        in_valid = 4'b0101;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            #2;
            if (burst_abort) begin
                wait_k = k;
                break;
            end
        end
        check_cnt++;
        if (wait_k != TO) $display("FAIL to_latency: got %0d want %0d", wait_k, TO);
        else pass_cnt++;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            #2;
            if (burst_abort) extra++;
        end
        check_cnt++;
        if (extra != 0) $display("FAIL to_single_pulse: extra pulses %0d want 0", extra);
        else pass_cnt++;
        check_cnt++;
        if (obs.size() < 3) begin
            $display("FAIL to_beats: got %0d want >=3", obs.size());
            return;
        end
        pass_cnt++;
        for (int n = 0; n < 2; n++) begin
            check_cnt++;
            if (obs[n].dest != 1 || obs[n].data !== sample_mem[1][n])
                $display("FAIL to_beat%0d: dest %0d data %0h want dest 1 data %0h",
                         n, obs[n].dest, obs[n].data, sample_mem[1][n]);
            else pass_cnt++;
        end
        check_cnt++;
        if (obs[2].dest != 2) $display("FAIL to_next_grant: got %0d want 2", obs[2].dest);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        in_valid = '1;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 50 && src_cnt[0] != 8'd3; k++) @(negedge clock);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #2;
            check_cnt++;
            if (out_valid !== 1'b1 || out_dest !== 2'd0 || out_data !== sample_mem[0][2])
                $display("FAIL bp_hold%0d: valid %0b dest %0d data %0h want 1 0 %0h",
                         k, out_valid, out_dest, out_data, sample_mem[0][2]);
            else pass_cnt++;
            check_cnt++;
            if (burst_abort !== 1'b0) $display("FAIL bp_abort%0d: got 1 want 0", k);
            else pass_cnt++;
        end
        check_cnt++;
        if (src_cnt[0] != 8'd3) $display("FAIL bp_no_accept: got %0d want 3", src_cnt[0]);
        else pass_cnt++;
        @(negedge clock);
        out_ready = 1'b1;
        for (int k = 0; k < 50 && obs.size() < 5; k++) @(negedge clock);
        #2;
        check_cnt++;
        if (obs.size() < 5) begin
            $display("FAIL bp_resume: got %0d beats want 5", obs.size());
            return;
        end
        pass_cnt++;
        for (int n = 0; n < BL; n++) begin
            check_cnt++;
            if (obs[n].dest != 0 || obs[n].data !== sample_mem[0][n])
                $display("FAIL bp_beat%0d: dest %0d data %0h want 0 %0h",
                         n, obs[n].dest, obs[n].data, sample_mem[0][n]);
            else pass_cnt++;
        end
        check_cnt++;
        if (obs[4].dest != 1) $display("FAIL bp_next: got %0d want 1", obs[4].dest);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        int bad = 0;
        int n3 = 0;
        in_valid = '1;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 100 && src_cnt[3] != 8'd1; k++) @(negedge clock);
        channel_enable = 4'b0111;
        @(negedge clock);
        #2;
        check_cnt++;
        if (burst_abort !== 1'b1) $display("FAIL dis_abort: got %0b want 1", burst_abort);
        else pass_cnt++;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            #2;
            if (in_ready[3]) bad++;
        end
        check_cnt++;
        if (bad != 0 || src_cnt[3] != 8'd1)
            $display("FAIL dis_no_regrant: ready cycles %0d beats %0d want 0 1", bad, src_cnt[3]);
        else pass_cnt++;
        foreach (obs[i]) if (obs[i].dest == 3) n3++;
        check_cnt++;
        if (n3 != 1) $display("FAIL dis_delivered: got %0d ch3 beats want 1", n3);
        else pass_cnt++;
        @(negedge clock);
        channel_enable = '1;
        for (int k = 0; k < 50 && src_cnt[3] == 8'd1; k++) @(negedge clock);
        check_cnt++;
        if (src_cnt[3] == 8'd1) $display("FAIL dis_reenable: ch3 beats %0d want >1", src_cnt[3]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        in_valid = '1;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 50 && src_cnt[1] != 8'd2; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #2;
        check_cnt++;
        if (out_valid !== 1'b0 || active_channel !== 2'd0 || in_ready !== 4'b0)
            $display("FAIL mid_rst: valid %0b active %0d ready %b want 0 0 0000",
                     out_valid, active_channel, in_ready);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        obs.delete();
        for (int k = 0; k < 20 && obs.size() < 1; k++) @(negedge clock);
        #2;
        check_cnt++;
        if (obs.size() < 1) begin
            $display("FAIL mid_rst_regrant: no beat after release");
            return;
        end
        pass_cnt++;
        check_cnt++;
        if (obs[0].dest != 0 || obs[0].data !== sample_mem[0][0])
            $display("FAIL mid_rst_first: dest %0d data %0h want 0 %0h",
                     obs[0].dest, obs[0].data, sample_mem[0][0]);
        else pass_cnt++;
    endtask

`ifdef ADC_ARB_STATS_EN
    task automatic test_stats();
        in_valid = 4'b0001;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 50 && src_cnt[0] != 8'd1; k++) @(negedge clock);
        channel_enable = 4'b1110;
        @(negedge clock);
        channel_enable = '1;
        in_valid = '1;
        for (int k = 0; k < 300 && src_cnt[0] != 8'd13; k++) @(negedge clock);
        in_valid = '0;
        repeat (4) @(negedge clock);
        #2;
        for (int i = 0; i < N; i++) begin
            check_cnt++;
            if (grant_count[i*16 +: 16] !== 16'd3)
                $display("FAIL stats_ch%0d: got %0d want 3", i, grant_count[i*16 +: 16]);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_random();
        logic        p_ov;
        logic        p_or;
        logic [15:0] p_data;
        logic [1:0]  p_dest;
        int          sz;
        in_valid = '1;
        channel_enable = '1;
        out_ready = 1'b1;
        do_reset();
        p_ov = 1'b0;
        p_or = 1'b1;
        p_data = '0;
        p_dest = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            out_ready = ($urandom_range(0, 9) < 6);
            #2;
            check_cnt++;
            if (!$onehot0(in_ready)) $display("FAIL rnd_onehot%0d: in_ready %b", c, in_ready);
            else pass_cnt++;
            if (p_ov && !p_or) begin
                check_cnt++;
                if (out_valid !== 1'b1 || out_data !== p_data || out_dest !== p_dest)
                    $display("FAIL rnd_stable%0d: valid %0b data %0h dest %0d want 1 %0h %0d",
                             c, out_valid, out_data, out_dest, p_data, p_dest);
                else pass_cnt++;
            end
            p_ov = out_valid;
            p_or = out_ready;
            p_data = out_data;
            p_dest = out_dest;
        end
        @(negedge clock);
        out_ready = 1'b1;
        #2;
        sz = obs.size();
        check_cnt++;
        if (sz < 100) begin
            $display("FAIL rnd_throughput: got %0d beats want >=100", sz);
            return;
        end
        pass_cnt++;
        for (int n = 0; n < sz; n++) begin
            int ch = (n / BL) % N;
            int ix = (n / (BL * N)) * BL + (n % BL);
            check_cnt++;
            if (obs[n].dest != ch || obs[n].data !== sample_mem[ch][ix])
                $display("FAIL rnd_beat%0d: dest %0d data %0h want %0d %0h",
                         n, obs[n].dest, obs[n].data, ch, sample_mem[ch][ix]);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 256; j++)
                sample_mem[i][j] = 16'($urandom);
        test_reset();
        test_round_robin();
        test_single_channel();
        test_timeout_abort();
        test_backpressure();
        test_disable();
        test_reset_mid_burst();
`ifdef ADC_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
